// File: rtl/dta_ingr_rcv_pkg.sv
//------------------------------------------------------------------------------
// Module      : dta_ingr_rcv_pkg
// Description : Shared constants and types for the ingress-receive protocol
//               error path (fault bit indices, valid-bit mask, FSM states).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dta_ingr_rcv_pkg;

    // Fault bit positions as assigned by the protocol monitor; 10, 11, 14 and 15 are reserved
    localparam int unsigned C_ERR_BIT_SOF_MISSING    = 0;
    localparam int unsigned C_ERR_BIT_EOF_MISSING    = 1;
    localparam int unsigned C_ERR_BIT_LEN_OVERRUN    = 2;
    localparam int unsigned C_ERR_BIT_LEN_UNDERRUN   = 3;
    localparam int unsigned C_ERR_BIT_HDR_CRC        = 4;
    localparam int unsigned C_ERR_BIT_PAYLOAD_CRC    = 5;
    localparam int unsigned C_ERR_BIT_SEQ_GAP        = 6;
    localparam int unsigned C_ERR_BIT_SEQ_DUP        = 7;
    localparam int unsigned C_ERR_BIT_BAD_TYPE       = 8;
    localparam int unsigned C_ERR_BIT_BAD_CHANNEL    = 9;
    localparam int unsigned C_ERR_BIT_FIFO_OVERFLOW  = 12;
    localparam int unsigned C_ERR_BIT_ALIGN          = 13;

    localparam logic [15:0] PROTOCOL_ERROR_VALID_MASK = 16'h33FF;

    typedef enum logic [0:0] {
        FIRST_ARMED    = 1'b0,
        FIRST_CAPTURED = 1'b1
    } first_state_e;

    function automatic logic [15:0] valid_error_bits(input logic [15:0] raw);
        return raw & PROTOCOL_ERROR_VALID_MASK;
    endfunction

endpackage : dta_ingr_rcv_pkg

`default_nettype wire

// File: rtl/dta_sat_counter.sv
//------------------------------------------------------------------------------
// Module      : dta_sat_counter
// Description : Parameterised saturating up-counter; clear with a concurrent
//               increment loads 1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dta_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (count_q != C_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : dta_sat_counter

`default_nettype wire

// File: rtl/dta_ingr_rcv_protocol_error_collector.sv
//------------------------------------------------------------------------------
// Module      : dta_ingr_rcv_protocol_error_collector
// Description : Collects protocol-monitor error reports into a sticky word,
//               first-error capture, saturating event count and level irq.
//               Optional first-error timestamp: DTA_INGR_RCV_PROTOCOL_ERROR_TIMESTAMP_EN
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dta_ingr_rcv_protocol_error_collector
    import dta_ingr_rcv_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int TS_WIDTH    = 48
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [15:0]            protocol_error,
    input  logic                   protocol_error_ap_vld,
    input  logic [15:0]            error_mask,
    input  logic [15:0]            error_clear,
    input  logic                   error_clear_ap_vld,
    input  logic                   count_clear,
    input  logic                   first_rearm,
    output logic [15:0]            error_sticky,
    output logic [15:0]            error_first,
    output logic                   first_valid,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic [TS_WIDTH-1:0]    first_timestamp,
    output logic                   error_irq
);

    logic [15:0]  vld_err;
    logic [15:0]  unmasked;
    logic         evt;
    logic         capture;

    logic [15:0]  sticky_q;
    logic [15:0]  sticky_d;
    logic [15:0]  first_q;
    logic         irq_q;
    first_state_e state_q;
    first_state_e state_d;

    assign vld_err  = valid_error_bits(protocol_error);
    assign unmasked = vld_err & ~error_mask;
    assign evt      = protocol_error_ap_vld && (unmasked != 16'h0000);
    assign capture  = (state_q == FIRST_ARMED) && evt;

    // Clear is applied before set so a same-cycle report always survives
    always_comb begin
        sticky_d = sticky_q;
        if (error_clear_ap_vld) begin
            sticky_d = sticky_d & ~error_clear;
        end
        if (protocol_error_ap_vld) begin
            sticky_d = sticky_d | vld_err;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FIRST_ARMED: begin
                if (evt) begin
                    state_d = FIRST_CAPTURED;
                end
            end
            FIRST_CAPTURED: begin
                if (first_rearm) begin
                    state_d = FIRST_ARMED;
                end
            end
            default: state_d = FIRST_ARMED;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sticky_q <= '0;
            first_q  <= '0;
            irq_q    <= 1'b0;
            state_q  <= FIRST_ARMED;
        end else begin
            sticky_q <= sticky_d;
            irq_q    <= |(sticky_q & ~error_mask);
            state_q  <= state_d;
            if (capture) begin
                first_q <= unmasked;
            end
        end
    end

    dta_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_err_cnt (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .inc_i   (evt),
        .clr_i   (count_clear),
        .count_o (error_count)
    );

`ifdef DTA_INGR_RCV_PROTOCOL_ERROR_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] first_ts_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ts_q       <= '0;
            first_ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
            if (capture) begin
                first_ts_q <= ts_q;
            end
        end
    end

    assign first_timestamp = first_ts_q;
`else
    assign first_timestamp = '0;
`endif

    assign error_sticky = sticky_q;
    assign error_first  = first_q;
    assign first_valid  = (state_q == FIRST_CAPTURED);
    assign error_irq    = irq_q;

endmodule : dta_ingr_rcv_protocol_error_collector

`default_nettype wire

// File: tb/tb_dta_ingr_rcv_protocol_error_collector.sv
//------------------------------------------------------------------------------
// Module      : tb_dta_ingr_rcv_protocol_error_collector
// Description : Scoreboard bench for the protocol error collector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dta_ingr_rcv_protocol_error_collector;

    localparam int CW = 4;
    localparam int TW = 48;
    localparam logic [CW-1:0] C_CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   pe = '0;
    logic          pe_vld = 1'b0;
    logic [15:0]   mask = '0;
    logic [15:0]   eclr = '0;
    logic          eclr_vld = 1'b0;
    logic          cclr = 1'b0;
    logic          rearm = 1'b0;
    logic [15:0]   sticky;
    logic [15:0]   first;
    logic          fvalid;
    logic [CW-1:0] count;
    logic [TW-1:0] fts;
    logic          irq;

    always #5 clk = ~clk;

    dta_ingr_rcv_protocol_error_collector #(
        .COUNT_WIDTH (CW),
        .TS_WIDTH    (TW)
    ) dut (
        .ap_clk                (clk),
        .ap_rst                (rst),
        .protocol_error        (pe),
        .protocol_error_ap_vld (pe_vld),
        .error_mask            (mask),
        .error_clear           (eclr),
        .error_clear_ap_vld    (eclr_vld),
        .count_clear           (cclr),
        .first_rearm           (rearm),
        .error_sticky          (sticky),
        .error_first           (first),
        .first_valid           (fvalid),
        .error_count           (count),
        .first_timestamp       (fts),
        .error_irq             (irq)
    );

    typedef struct {
        logic [15:0]   sticky;
        logic [15:0]   first;
        logic          valid;
        logic [CW-1:0] count;
        logic [TW-1:0] fts;
        logic          irq;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;

    // Reference state
    logic [15:0]   m_sticky = '0;
    logic [15:0]   m_first  = '0;
    logic          m_valid  = 1'b0;
    logic [CW-1:0] m_count  = '0;
    logic [TW-1:0] m_fts    = '0;
    logic          m_irq    = 1'b0;
    logic [TW-1:0] m_ts     = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sticky = '0; m_first = '0; m_valid = 1'b0;
        m_count = '0; m_fts = '0; m_irq = 1'b0; m_ts = '0;
    endtask

    // Predict next state from current inputs, push, clock, pop and compare
    task automatic cycle();
        exp_t        e;
        logic [15:0] ve;
        logic [15:0] um;
        logic        ev;
        ve = pe & 16'h33FF;
        um = ve & ~mask;
        ev = pe_vld && (um != 16'h0);
        e.sticky = (m_sticky & ~(eclr_vld ? eclr : 16'h0)) | (pe_vld ? ve : 16'h0);
        if (cclr)                            e.count = ev ? CW'(1) : '0;
        else if (ev && (m_count != C_CMAX))  e.count = m_count + CW'(1);
        else                                 e.count = m_count;
        e.valid = m_valid;
        e.first = m_first;
        e.fts   = m_fts;
        if (!m_valid) begin
            if (ev) begin
                e.valid = 1'b1;
                e.first = um;
`ifdef DTA_INGR_RCV_PROTOCOL_ERROR_TIMESTAMP_EN
                e.fts   = m_ts;
`endif
            end
        end else if (rearm) begin
            e.valid = 1'b0;
        end
        e.irq = |(m_sticky & ~mask);
        sb.push_back(e);

        @(posedge clk);
        #1;
        m_sticky = e.sticky; m_first = e.first; m_valid = e.valid;
        m_count = e.count; m_fts = e.fts; m_irq = e.irq;
        m_ts = m_ts + TW'(1);

        e = sb.pop_front();
        check("sticky", 64'(sticky), 64'(e.sticky));
        check("first",  64'(first),  64'(e.first));
        check("valid",  64'(fvalid), 64'(e.valid));
        check("count",  64'(count),  64'(e.count));
        check("fts",    64'(fts),    64'(e.fts));
        check("irq",    64'(irq),    64'(e.irq));
    endtask

    task automatic drive(input logic [15:0] p, input logic pv, input logic [15:0] c,
                         input logic cv, input logic cc, input logic ra);
        pe = p; pe_vld = pv; eclr = c; eclr_vld = cv; cclr = cc; rearm = ra;
        cycle();
        pe = '0; pe_vld = 1'b0; eclr = '0; eclr_vld = 1'b0; cclr = 1'b0; rearm = 1'b0;
    endtask

    task automatic idle();
        drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_sticky", 64'(sticky), 64'h0);
        check("rst_count",  64'(count),  64'h0);
        check("rst_valid",  64'(fvalid), 64'h0);
        check("rst_irq",    64'(irq),    64'h0);
        check("rst_fts",    64'(fts),    64'h0);
        rst = 1'b0;

        // Basic event
        drive(16'h0041, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t1_sticky", 64'(sticky), 64'h0041);
        check("t1_count",  64'(count),  64'h1);
        check("t1_first",  64'(first),  64'h0041);
        check("t1_valid",  64'(fvalid), 64'h1);
        check("t1_irq_n1", 64'(irq),    64'h0);
        idle();
        check("t1_irq_n2", 64'(irq),    64'h1);

        // Reserved bits never set
        drive(16'hFFFF, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t2_sticky", 64'(sticky), 64'h33FF);
        check("t2_first",  64'(first),  64'h0041);

        drive(16'h0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        idle();
        check("t2_clr_irq", 64'(irq), 64'h0);

        // Masked event: sticky only
        mask = 16'h0040;
        drive(16'h0040, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t3_sticky", 64'(sticky), 64'h0040);
        check("t3_count",  64'(count),  64'h0);
        check("t3_valid",  64'(fvalid), 64'h0);
        idle();
        check("t3_irq",    64'(irq),    64'h0);
        mask = 16'h0000;
        idle();
        check("t3_unmask_irq", 64'(irq), 64'h1);

        // Set beats clear, then clear alone
        drive(16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        check("t4_set_wins", 64'(sticky[0]), 64'h1);
        drive(16'h0, 1'b0, 16'h0041, 1'b1, 1'b0, 1'b0);
        check("t4_cleared", 64'(sticky), 64'h0);
        check("t4_irq_hold", 64'(irq), 64'h1);
        idle();
        check("t4_irq_drop", 64'(irq), 64'h0);

        // Saturation
        drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < int'(C_CMAX) - 1; i++) drive(16'h0002, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t5_near_max", 64'(count), 64'(C_CMAX - CW'(1)));
        for (int i = 0; i < 3; i++) drive(16'h0004, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t5_sat", 64'(count), 64'(C_CMAX));
        drive(16'h0008, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check("t5_clr_inc", 64'(count), 64'h1);

        // Rearm with event while captured leaves block armed and empty
        drive(16'h0010, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
        check("t6_rearm_evt", 64'(fvalid), 64'h0);

        // Constrained random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) mask = 16'($urandom);
            drive(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset mid-operation
        mask = '0;
        drive(16'h0100, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sticky", 64'(sticky), 64'h0);
        check("arst_count",  64'(count),  64'h0);
        check("arst_first",  64'(first),  64'h0);
        check("arst_valid",  64'(fvalid), 64'h0);
        check("arst_fts",    64'(fts),    64'h0);
        model_reset();
        rst = 1'b0;
        idle();
        check("arst_irq", 64'(irq), 64'h0);

`ifdef DTA_INGR_RCV_PROTOCOL_ERROR_TIMESTAMP_EN
        for (int g = 0; g < 1000 && m_ts != TW'(100); g++) idle();
        drive(16'h0020, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("ts_first", 64'(fts), 64'd100);
        drive(16'h0020, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("ts_hold", 64'(fts), 64'd100);
        drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 1000 && m_ts != TW'(200); g++) idle();
        drive(16'h0200, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check("ts_second", 64'(fts), 64'd200);
`else
        for (int i = 0; i < 20; i++) drive(16'h0020, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
        check("ts_tied", 64'(fts), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dta_ingr_rcv_protocol_error_collector

`default_nettype wire

// File: doc/dta_ingr_rcv_protocol_error_collector.md
# dta_ingr_rcv_protocol_error_collector

Sits directly downstream of the ingress-receive protocol monitor and consumes its `protocol_error`/`protocol_error_ap_vld` report stream. It accumulates reports into a sticky status word, captures the first unmasked error, counts error events with saturation, and raises a level interrupt. All outputs feed the control/status register block.

## Interface
Parameters:
- `COUNT_WIDTH`, default 32: width of the error event counter.
- `TS_WIDTH`, default 48: width of the free-running cycle counter and the first-error timestamp.

Ports:
- `ap_clk`  in  1: single clock.
- `ap_rst`  in  1: reset, asynchronous and active-high.
- `protocol_error`  in  16: fault bit vector from the monitor. Bits 10, 11, 14 and 15 are reserved.
- `protocol_error_ap_vld`  in  1: qualifies `protocol_error` for one cycle.
- `error_mask`  in  16: quasi-static CSR value. 1 = bit excluded from count, first-capture and irq.
- `error_clear`  in  16: write-1-to-clear bits for the sticky word.
- `error_clear_ap_vld`  in  1: qualifies `error_clear`.
- `count_clear`  in  1: single-cycle pulse that zeroes the counter.
- `first_rearm`  in  1: single-cycle pulse that re-arms first-error capture.
- `error_sticky`  out  16: accumulated fault bits, unmasked view.
- `error_first`  out  16: first unmasked error vector captured.
- `first_valid`  out  1: `error_first` holds a capture.
- `error_count`  out  `COUNT_WIDTH`: saturating count of unmasked error events.
- `first_timestamp`  out  `TS_WIDTH`: cycle stamp of the first capture.
- `error_irq`  out  1: level interrupt.

## Operation
- Definitions:
  - `vld_err = protocol_error & 16'h33FF`, i.e. reserved bits are forced to 0.
  - `unmasked = vld_err & ~error_mask`.
  - An event is any cycle with `protocol_error_ap_vld=1` and `unmasked != 0`.
- **Sticky word:**
  - `sticky_next = (sticky & ~(error_clear_ap_vld ? error_clear : 0)) | (protocol_error_ap_vld ? vld_err : 0)`.
  - Set wins over clear for the same bit in the same cycle.
  - Masked bits still set the sticky word; the mask only gates count, capture and irq.
- **Counter:**
  - Increments by 1 per event and saturates at all-ones; it never wraps.
  - `count_clear` together with an event yields 1. `count_clear` alone yields 0.
- **First-capture FSM**, two states:
  - ARMED → CAPTURED on an event. Latches `error_first = unmasked` and sets `first_valid=1`.
  - CAPTURED holds and ignores further events.
  - CAPTURED → ARMED on `first_rearm`. `error_first` is held, `first_valid` clears.
  - `first_rearm` together with an event in ARMED: the capture happens and the rearm is ignored.
  - `first_rearm` together with an event in CAPTURED: the block ends in ARMED with nothing captured.
- **Interrupt:** `error_irq = |(error_sticky & ~error_mask)`, registered.
  - A mask change takes effect on irq one cycle later.
  - Clearing every unmasked sticky bit deasserts irq.
- **Reset:** every output and all state go to 0 and the FSM goes to ARMED. Assertion mid-operation discards everything immediately, asynchronously.

## Timing
- Inputs are sampled on `ap_clk` rising edges. There is no backpressure; the monitor may report on consecutive cycles and every cycle is counted.
- Latency from `protocol_error_ap_vld` at cycle N:
  - `error_sticky`, `error_count`, `error_first`, `first_valid` and `first_timestamp` are updated at N+1.
  - `error_irq` asserts at N+2.
- Clear latency: `error_clear_ap_vld`, `count_clear` or `first_rearm` at cycle N takes effect at N+1; `error_irq` follows at N+2.
- Reset values:
  - `error_sticky = 0`, `error_first = 0`, `first_valid = 0`.
  - `error_count = 0`, `first_timestamp = 0`, `error_irq = 0`.

## Configuration
- Macro `DTA_INGR_RCV_PROTOCOL_ERROR_TIMESTAMP_EN`.
- **Defined:**
  - A free-running `TS_WIDTH` cycle counter runs from reset and wraps at all-ones to 0.
  - On capture, `first_timestamp` latches the counter value of the event cycle N.
- **Undefined:**
  - The counter is not built.
  - `first_timestamp` is tied to 0; the port remains present so the interface is identical.

## Structure
- Shared package `dta_ingr_rcv_pkg` holds:
  - the fault bit-index constants (bits 0..13 per monitor assignment);
  - `PROTOCOL_ERROR_VALID_MASK = 16'h33FF`;
  - the FSM state typedef (`FIRST_ARMED`, `FIRST_CAPTURED`).
- One sub-module, `dta_sat_counter`: a parameterised-width saturating counter with `inc` and `clr` inputs, where `clr`+`inc` gives 1. It implements `error_count`.

## Test plan
- Inject `protocol_error=16'h0041` with vld, `error_mask=0`:
  - N+1: `error_sticky=0x0041`, `error_count=1`, `error_first=0x0041`, `first_valid=1`.
  - N+2: `error_irq=1`.
- Inject `16'hFFFF` with vld → `error_sticky=0x33FF`; the reserved bits never set.
- `error_mask=0x0040`, inject `0x0040`:
  - `error_sticky=0x0040`, `error_count` unchanged, `first_valid` stays 0, `error_irq=0`.
  - Then set `error_mask=0` → irq asserts 1 cycle later.
- Same cycle: `error_clear=0x0001` with vld and `protocol_error=0x0001` with vld → bit 0 stays set.
  - Next cycle, clear alone → sticky bit 0 = 0 and irq drops 1 cycle later.
- Force the counter to `2^COUNT_WIDTH-2` and inject 3 events → `error_count` stays at all-ones.
  - Then `count_clear` concurrent with an event → `error_count=1`.
- With the macro defined: reset release, event at cycle 100 after reset → `first_timestamp=100`.
  - A second event does not change it.
  - After `first_rearm`, an event at cycle 200 captures 200.
  - With the macro undefined, `first_timestamp` is always 0.
